cpu_sequencer: RTL and testbench

//   Multi-cycle control FSM for the CPU core. It fetches instructions over an imem req/ack handshake and holds them in the IR that feeds decode.
//   It steps each instruction through DECODE/EXEC/MEM/WB using decode's mr_sel/mw_sel/rw_sel, drives dmem req/ack and register-file write enable,
//   and owns the PC, the retire counter and a memory-timeout error trap.

---
 rtl/cpu_sequencer.sv | 156 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch, decode, exec, mem, writeback.
// Owns the PC, IR, retire counter and the memory-timeout error trap.
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    input  logic             mr_sel,
    input  logic             mw_sel,
    input  logic             rw_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic [31:0]      pc,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd7
    } state_t;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST =
        (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam bit TMO_EN = (TIMEOUT > 0);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             imem_req_q, imem_req_d;
    logic             dmem_req_q, dmem_req_d;
    logic             dmem_we_q, dmem_we_d;
    logic             rf_we_q, rf_we_d;
    logic             err_q, err_d;
    logic             retire_c;
    logic             tmo_hit;
    logic [TW-1:0]    tmo_inc;

    assign tmo_hit = TMO_EN && (tmo_q == TMO_LAST);
    assign tmo_inc = TMO_EN ? tmo_q + TW'(1) : '0;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        tmo_d    = '0;
        retire_c = 1'b0;
        unique case (state_q)
            // first cycle after reset has no request out yet
            S_FETCH: begin
                if (imem_req_q) begin
                    if (imem_ack) begin
                        ir_d    = imem_rdata;
                        state_d = S_DECODE;
                    end else if (tmo_hit) begin
                        state_d = S_ERR;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (mw_sel || mr_sel) begin
                    state_d = S_MEM;
                end else if (rw_sel) begin
                    state_d = S_WB;
                end else begin
                    retire_c = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (dmem_we_q) retire_c = 1'b1;
                    else           state_d  = S_WB;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WB:  retire_c = 1'b1;
            S_ERR: state_d  = S_ERR;
            default: state_d = S_ERR;
        endcase
        if (retire_c) begin
            pc_d    = pc_q + 32'd4;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_FETCH;
        end
        imem_req_d = (state_d == S_FETCH);
        dmem_req_d = (state_d == S_MEM);
        dmem_we_d  = (state_d == S_MEM) &&
                     ((state_q == S_EXEC) ? mw_sel : dmem_we_q);
        rf_we_d    = (state_d == S_WB);
        err_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
            dmem_we_q  <= dmem_we_d;
            rf_we_q    <= rf_we_d;
            err_q      <= err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign rf_we       = rf_we_q;
    assign pc          = pc_q;
    assign retire      = retire_c;
    assign instr_count = cnt_q;
    assign err         = err_q;
    assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed fetch/load/store/nop,
// timeout trap, mid-access reset, and PC/counter wrap on a second instance.
module tb_cpu_sequencer;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] LW   = 32'h0000_A103;
    localparam logic [31:0] SW   = 32'h0020_A023;
    localparam logic [31:0] NOP  = 32'h0000_000F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        rfwe;
        logic        st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata, ir, pc;
    logic        mr_sel, mw_sel, rw_sel;
    logic        dmem_req, dmem_we, dmem_ack, rf_we, retire, err;
    logic [31:0] instr_count;
    logic [2:0]  state;

    logic        imem_req2, dmem_req2, dmem_we2, rf_we2;
    logic        retire2, err2;
    logic [31:0] imem_addr2, ir2, pc2;
    logic [1:0]  instr_count2;
    logic [2:0]  state2;
    logic        imem_ack2;

    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    cpu_sequencer u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .mr_sel(mr_sel), .mw_sel(mw_sel), .rw_sel(rw_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .retire(retire),
        .instr_count(instr_count), .err(err), .state(state)
    );

    assign imem_ack2 = imem_req2;

    cpu_sequencer #(
        .RESET_PC(32'hFFFF_FFFC), .TIMEOUT(0), .CNT_W(2)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack2), .imem_rdata(ADDI),
        .ir(ir2), .mr_sel(1'b0), .mw_sel(1'b0), .rw_sel(1'b1),
        .dmem_req(dmem_req2), .dmem_we(dmem_we2), .dmem_ack(1'b0),
        .rf_we(rf_we2), .pc(pc2), .retire(retire2),
        .instr_count(instr_count2), .err(err2), .state(state2)
    );

    always_comb begin
        mr_sel = (ir[6:0] == 7'b0000011);
        mw_sel = (ir[6:0] == 7'b0100011);
        rw_sel = (ir[6:0] == 7'b0010011) ||
                 (ir[6:0] == 7'b0110011) || mr_sel;
    end

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        #4;
        if (rst_n && retire) begin
            if (q1.size() == 0) begin
                chk("retire_unexpected", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("ret_pc", pc, e.pc);
                chk("ret_cnt", instr_count, e.cnt);
                chk("ret_rfwe", {31'd0, rf_we}, {31'd0, e.rfwe});
                chk("ret_store", {31'd0, dmem_req & dmem_we},
                    {31'd0, e.st});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #4;
        if (rst_n && retire2 && q2.size() != 0) begin
            e = q2.pop_front();
            chk("wrap_pc", pc2, e.pc);
            chk("wrap_cnt", {30'd0, instr_count2}, e.cnt);
            chk("wrap_rfwe", {31'd0, rf_we2}, {31'd0, e.rfwe});
        end
    end

    task automatic fetch(input logic [31:0] ins, input int lat);
        int t = 0;
        while (!imem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        repeat (lat) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic dmem(input int lat, input logic we);
        int t = 0;
        int n = 0;
        while (!dmem_req && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("dmem_req_seen", {31'd0, dmem_req}, 32'd1);
        chk("dmem_we", {31'd0, dmem_we}, {31'd0, we});
        for (int i = 0; i <= lat; i++) begin
            dmem_ack = (i == lat);
            if (dmem_req) n++;
            if (rf_we) chk("rf_we_in_mem", 32'd1, 32'd0);
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        chk("dmem_req_cycles", n, lat + 1);
    endtask

    initial begin
        int n;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        #12;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_wrap_pc", pc2, 32'hFFFF_FFFC);
        q2.push_back('{32'hFFFF_FFFC, 32'd0, 1'b1, 1'b0});
        q2.push_back('{32'h0000_0000, 32'd1, 1'b1, 1'b0});
        q2.push_back('{32'h0000_0004, 32'd2, 1'b1, 1'b0});
        q2.push_back('{32'h0000_0008, 32'd3, 1'b1, 1'b0});
        q2.push_back('{32'h0000_000C, 32'd0, 1'b1, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_imem_req", {31'd0, imem_req}, 32'd1);
        chk("imem_addr", imem_addr, 32'd0);

        q1.push_back('{32'd0, 32'd0, 1'b1, 1'b0});
        fetch(ADDI, 0);
        chk("addi_decode", {29'd0, state}, 32'd1);
        chk("addi_ir", ir, ADDI);
        @(negedge clk);
        chk("addi_exec", {29'd0, state}, 32'd2);
        @(negedge clk);
        chk("addi_wb", {29'd0, state}, 32'd4);
        chk("addi_rf_we", {31'd0, rf_we}, 32'd1);
        @(negedge clk);
        chk("addi_fetch", {29'd0, state}, 32'd0);
        chk("addi_rf_we_off", {31'd0, rf_we}, 32'd0);
        chk("addi_pc", pc, 32'd4);
        chk("addi_cnt", instr_count, 32'd1);

        q1.push_back('{32'd4, 32'd1, 1'b1, 1'b0});
        fetch(LW, 1);
        dmem(3, 1'b0);
        chk("lw_wb", {29'd0, state}, 32'd4);
        chk("lw_rf_we", {31'd0, rf_we}, 32'd1);
        chk("lw_dmem_off", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        chk("lw_pc", pc, 32'd8);

        q1.push_back('{32'd8, 32'd2, 1'b0, 1'b1});
        fetch(SW, 0);
        dmem(2, 1'b1);
        chk("sw_fetch", {29'd0, state}, 32'd0);
        chk("sw_pc", pc, 32'd12);
        chk("sw_no_rf_we", {31'd0, rf_we}, 32'd0);
        chk("sw_we_off", {31'd0, dmem_we}, 32'd0);

        q1.push_back('{32'd12, 32'd3, 1'b0, 1'b0});
        fetch(NOP, 0);
        @(negedge clk);
        @(negedge clk);
        chk("nop_fetch", {29'd0, state}, 32'd0);
        chk("nop_pc", pc, 32'd16);
        chk("nop_cnt", instr_count, 32'd4);

        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, 16);
        chk("tmo_state", {29'd0, state}, 32'd7);
        chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_imem_req", {31'd0, imem_req}, 32'd0);
        chk("tmo_pc", pc, 32'd16);
        imem_ack   = 1'b1;
        imem_rdata = ADDI;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        chk("err_sticky", {29'd0, state}, 32'd7);
        chk("err_ir_frozen", ir, NOP);
        chk("q2_drained", q2.size(), 0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fetch(LW, 0);
        n = 0;
        while (!dmem_req && n < 20) begin
            n++;
            @(negedge clk);
        end
        @(negedge clk);
        chk("mr_in_mem", {29'd0, state}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_state", {29'd0, state}, 32'd0);
        chk("arst_rf_we", {31'd0, rf_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_refetch", {31'd0, imem_req}, 32'd1);
        q1.push_back('{32'd0, 32'd0, 1'b1, 1'b0});
        fetch(ADDI, 0);
        repeat (3) @(negedge clk);
        chk("post_rst_pc", pc, 32'd4);
        chk("q1_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
